spi_master_param: RTL and testbench

Parametrised full-duplex SPI master that supersedes the fixed 8-bit transfer logic. Supports configurable word width, clock divider and number of slave selects, plus run-time selection of all four SPI modes (CPOL/CPHA) and MSB/LSB-first ordering. It sits between a local controller, which exchanges words through a start/done handshake, and the external SPI pins.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_clk_div.sv | 29 ++
 rtl/spi_master_param.sv | 137 +++++++++++++
 tb/tb_spi_master_param.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM encodings, mode constants and CPOL/CPHA field helpers.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int unsigned CPOL_BIT = 1;
  localparam int unsigned CPHA_BIT = 0;

  function automatic logic mode_cpol(input logic [1:0] m);
    return m[CPOL_BIT];
  endfunction

  function automatic logic mode_cpha(input logic [1:0] m);
    return m[CPHA_BIT];
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: counts while enabled, restarts from 0 on clear.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 16
) (
  input  logic global_clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(CLK_DIV - 1));

  // Free-running modulo-CLK_DIV counter, held at 0 while cleared.
  always_ff @(posedge global_clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master with run-time mode and bit-order selection.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 16,
  parameter int unsigned NUM_SS  = 2,
  localparam int unsigned SS_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              global_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SS_W-1:0]   ss_sel,
  input  logic [1:0]        mode,
  input  logic              lsb_first,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int unsigned EW = $clog2(2 * DATA_W + 1);

  spi_state_e        state_q, state_d;
  logic              tick, div_clr, accept, last_edge, odd_edge;
  logic              cpol_q, cpha_q, lsb_q;
  logic [SS_W-1:0]   ss_q;
  logic [DATA_W-1:0] tx_sh, rx_sh;
  logic [EW-1:0]     edge_cnt;

  function automatic logic out_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_w(input logic [DATA_W-1:0] w,
                                                input logic lsb, input logic in);
    return lsb ? {in, w[DATA_W-1:1]} : {w[DATA_W-2:0], in};
  endfunction

  assign accept    = (state_q == IDLE) && start && (32'(ss_sel) < NUM_SS);
  assign last_edge = (edge_cnt == EW'(2 * DATA_W - 1));
  // edge_cnt is 0-based, so an even count is an odd-numbered (leading) edge
  assign odd_edge  = ~edge_cnt[0];
  assign busy      = (state_q != IDLE);
  assign div_clr   = (state_q == IDLE) || (state_d != state_q);

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .global_clk (global_clk),
    .reset      (reset),
    .en         (busy),
    .clr        (div_clr),
    .tick       (tick)
  );

  // FSM state register.
  always_ff @(posedge global_clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: each non-idle phase ends on a divider tick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept)            state_d = SETUP;
      SETUP: if (tick)              state_d = XFER;
      XFER:  if (tick && last_edge) state_d = HOLD;
      HOLD:  if (tick)              state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Active-low one-hot slave select, driven only while a transfer is in progress.
  always_comb begin
    ss_n = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      ss_n[i] = !(busy && (ss_q == SS_W'(i)));
    end
  end

  // Datapath: config capture, SCLK generation, shift registers, result and done pulse.
  always_ff @(posedge global_clk or negedge reset) begin
    if (!reset) begin
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      ss_q     <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
      rx_data  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        cpol_q   <= mode_cpol(mode);
        cpha_q   <= mode_cpha(mode);
        lsb_q    <= lsb_first;
        ss_q     <= ss_sel;
        sclk     <= mode_cpol(mode);
        edge_cnt <= '0;
        rx_sh    <= '0;
        // CPHA=0 needs the first bit on the wire before the first edge;
        // CPHA=1 presents it on the first edge instead.
        if (!mode_cpha(mode)) begin
          mosi  <= out_bit(tx_data, lsb_first);
          tx_sh <= shift_w(tx_data, lsb_first, 1'b0);
        end else begin
          tx_sh <= tx_data;
        end
      end else if (state_q == XFER && tick) begin
        sclk     <= ~sclk;
        edge_cnt <= edge_cnt + 1'b1;
        if (cpha_q ? !odd_edge : odd_edge) begin
          rx_sh <= shift_w(rx_sh, lsb_q, miso);
        end
        if (cpha_q ? odd_edge : (!odd_edge && !last_edge)) begin
          mosi  <= out_bit(tx_sh, lsb_q);
          tx_sh <= shift_w(tx_sh, lsb_q, 1'b0);
        end
      end else if (state_q == HOLD) begin
        sclk <= cpol_q;
        if (tick) begin
          rx_data <= rx_sh;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param with a behavioural SPI slave on the pins.
module tb_spi_master_param;
  import spi_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int unsigned DIV = 16;
  localparam int unsigned NSS = 5;
  localparam int unsigned LAT = 1 + (2 * DW + 2) * DIV;

  logic          global_clk = 1'b0;
  logic          reset      = 1'b0;
  logic          start      = 1'b0;
  logic [DW-1:0] tx_data    = '0;
  logic [2:0]    ss_sel     = '0;
  logic [1:0]    mode       = '0;
  logic          lsb_first  = 1'b0;
  logic          miso       = 1'b0;
  logic          busy, done, sclk, mosi;
  logic [DW-1:0] rx_data;
  logic [NSS-1:0] ss_n;

  spi_master_param #(.DATA_W(DW), .CLK_DIV(DIV), .NUM_SS(NSS)) dut (
    .global_clk (global_clk),
    .reset      (reset),
    .start      (start),
    .tx_data    (tx_data),
    .ss_sel     (ss_sel),
    .mode       (mode),
    .lsb_first  (lsb_first),
    .busy       (busy),
    .done       (done),
    .rx_data    (rx_data),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .ss_n       (ss_n)
  );

  always #5 global_clk = ~global_clk;

  int unsigned cyc = 0;
  always @(posedge global_clk) cyc <= cyc + 1;

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [DW-1:0] rx;
    int unsigned   issue;
  } exp_t;

  exp_t          rx_q[$];
  logic [DW-1:0] tx_q[$];

  // Slave model configuration (what the slave returns and how it frames bits)
  logic [1:0]    sl_mode = '0;
  logic          sl_lsb  = 1'b0;
  logic [DW-1:0] sl_word = '0;

  logic          sel_now, sel_prev = 1'b0, sclk_prev = 1'b0, lead;
  int unsigned   sl_edges;
  logic [DW-1:0] sl_out, sl_in;

  // Behavioural slave: drives miso, captures mosi, checks the captured word on deselect.
  always @(negedge global_clk) begin
    sel_now = (ss_n != '1);
    if (sel_now && !sel_prev) begin
      sl_edges = 0;
      sl_in    = '0;
      sl_out   = sl_word;
      if (!sl_mode[CPHA_BIT]) begin
        miso   = sl_lsb ? sl_out[0] : sl_out[DW-1];
        sl_out = sl_lsb ? (sl_out >> 1) : (sl_out << 1);
      end
    end else if (sel_now && (sclk !== sclk_prev)) begin
      sl_edges++;
      lead = sl_edges[0];
      if (sl_mode[CPHA_BIT] ? !lead : lead)
        sl_in = sl_lsb ? {mosi, sl_in[DW-1:1]} : {sl_in[DW-2:0], mosi};
      if (sl_mode[CPHA_BIT] ? lead : !lead) begin
        miso   = sl_lsb ? sl_out[0] : sl_out[DW-1];
        sl_out = sl_lsb ? (sl_out >> 1) : (sl_out << 1);
      end
    end
    if (!sel_now && sel_prev && (tx_q.size() > 0))
      check("mosi_word", 32'(sl_in), 32'(tx_q.pop_front()));
    sel_prev  = sel_now;
    sclk_prev = sclk;
  end

  // Done monitor: pops the oldest expected transfer and compares result and timing.
  always @(negedge global_clk) begin
    if (reset && done) begin
      if (rx_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        exp_t e;
        e = rx_q.pop_front();
        check("rx_data", 32'(rx_data), 32'(e.rx));
        check("latency", cyc - e.issue, LAT);
        check("busy_at_done", 32'(busy), 32'(0));
        check("ss_n_at_done", 32'(ss_n), 32'({NSS{1'b1}}));
      end
    end
  end

  // Issue one transfer with expectations; returns at the negedge of cycle 1.
  task automatic issue(input logic [DW-1:0] tx, input logic [2:0] sel, input logic [1:0] md,
                       input logic lsb, input logic [DW-1:0] sw, input logic [DW-1:0] rx_exp);
    exp_t e;
    sl_mode   = md;
    sl_lsb    = lsb;
    sl_word   = sw;
    tx_data   = tx;
    ss_sel    = sel;
    mode      = md;
    lsb_first = lsb;
    start     = 1'b1;
    e.rx      = rx_exp;
    e.issue   = cyc;
    rx_q.push_back(e);
    tx_q.push_back(tx);
    @(negedge global_clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(negedge global_clk);
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: no done within 400 cycles (cycle %0d)", cyc);
  endtask

  int unsigned c0;

  initial begin
    // Reset state
    repeat (3) @(negedge global_clk);
    check("rst_sclk", 32'(sclk), 32'(0));
    check("rst_mosi", 32'(mosi), 32'(0));
    check("rst_ss_n", 32'(ss_n), 32'(5'b11111));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_rx", 32'(rx_data), 32'(0));
    reset = 1'b1;
    repeat (2) @(negedge global_clk);

    // Mode 0, MSB first, 0xA5 out, slave returns 0x3C
    issue(8'hA5, 3'd0, SPI_MODE0, 1'b0, 8'h3C, 8'h3C);
    check("m0_busy_c1", 32'(busy), 32'(1));
    check("m0_ss_n_c1", 32'(ss_n), 32'(5'b11110));
    check("m0_sclk_c1", 32'(sclk), 32'(0));
    check("m0_mosi_c1", 32'(mosi), 32'(1));
    wait_done();
    @(negedge global_clk);

    // Mode 3, LSB first, 0x01 out, miso held high
    issue(8'h01, 3'd1, SPI_MODE3, 1'b1, 8'hFF, 8'hFF);
    check("m3_sclk_idle_hi", 32'(sclk), 32'(1));
    for (int i = 0; i < 40; i++) begin
      if (!sclk) break;
      @(negedge global_clk);
    end
    check("m3_sclk_fell", 32'(sclk), 32'(0));
    check("m3_first_mosi", 32'(mosi), 32'(1));
    wait_done();
    @(negedge global_clk);

    // Slave 2 select, mode 1, MSB first
    issue(8'h5A, 3'd2, SPI_MODE1, 1'b0, 8'hC3, 8'hC3);
    check("ss2_ss_n", 32'(ss_n), 32'(5'b11011));
    wait_done();
    @(negedge global_clk);

    // Out-of-range slave indices are ignored
    ss_sel = 3'd5;
    start  = 1'b1;
    @(negedge global_clk);
    check("bad_ss5_busy", 32'(busy), 32'(0));
    ss_sel = 3'd7;
    @(negedge global_clk);
    start = 1'b0;
    check("bad_ss7_busy", 32'(busy), 32'(0));
    check("bad_ss_ss_n", 32'(ss_n), 32'(5'b11111));
    repeat (3) @(negedge global_clk);

    // start pulsed mid-transfer with new settings has no effect
    issue(8'h96, 3'd3, SPI_MODE2, 1'b1, 8'h4D, 8'h4D);
    repeat (50) @(negedge global_clk);
    tx_data = 8'hFF;
    mode    = SPI_MODE0;
    ss_sel  = 3'd0;
    start   = 1'b1;
    @(negedge global_clk);
    start = 1'b0;
    check("mid_start_ss_n", 32'(ss_n), 32'(5'b10111));
    check("mid_start_sclk", 32'(sclk), 32'(1));
    wait_done();
    @(negedge global_clk);

    // Back-to-back: start held through the done cycle
    issue(8'hC5, 3'd4, SPI_MODE0, 1'b0, 8'h2B, 8'h2B);
    repeat (5) @(negedge global_clk);
    sl_word = 8'h71;
    tx_data = 8'h3E;
    ss_sel  = 3'd4;
    start   = 1'b1;
    wait_done();
    begin
      exp_t e;
      e.rx    = 8'h71;
      e.issue = cyc;
      rx_q.push_back(e);
      tx_q.push_back(8'h3E);
    end
    check("b2b_gap_high", 32'(ss_n), 32'(5'b11111));
    @(negedge global_clk);
    start = 1'b0;
    check("b2b_reselect", 32'(ss_n), 32'(5'b01111));
    check("b2b_busy", 32'(busy), 32'(1));
    wait_done();
    @(negedge global_clk);

    // Reset at cycle 100 of a transfer aborts it with no done
    sl_mode   = SPI_MODE3;
    sl_lsb    = 1'b1;
    sl_word   = 8'h00;
    tx_data   = 8'hFF;
    ss_sel    = 3'd1;
    mode      = SPI_MODE3;
    lsb_first = 1'b1;
    start     = 1'b1;
    c0        = cyc;
    @(negedge global_clk);
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cyc >= c0 + 100) break;
      @(negedge global_clk);
    end
    check("abort_busy_before", 32'(busy), 32'(1));
    reset = 1'b0;
    #1;
    check("abort_sclk", 32'(sclk), 32'(0));
    check("abort_mosi", 32'(mosi), 32'(0));
    check("abort_ss_n", 32'(ss_n), 32'(5'b11111));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    check("abort_rx", 32'(rx_data), 32'(0));
    repeat (3) @(negedge global_clk);
    reset = 1'b1;
    @(negedge global_clk);

    // Normal transfer after the abort
    issue(8'h3C, 3'd0, SPI_MODE0, 1'b0, 8'hA5, 8'hA5);
    wait_done();
    repeat (5) @(negedge global_clk);
    check("rx_hold", 32'(rx_data), 32'(8'hA5));
    check("scoreboard_drained", 32'(rx_q.size() + tx_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
